cfu_wb_buffer: RTL and testbench



---
 rtl/cfu_wb_buffer_pkg.sv | 30 +++
 rtl/cfu_wb_buffer.sv | 107 ++++++++++
 tb/tb_cfu_wb_buffer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cfu_wb_buffer_pkg.sv
// Shared types for the CFU writeback result buffer.
// Entry layout is reused by the issue stage writeback mux.
package cfu_wb_buffer_pkg;

   localparam int unsigned XLEN          = 32;
   localparam int unsigned TRANS_ID_BITS = 4;

   typedef logic [XLEN-1:0] xlen_t;

   typedef struct packed {
      xlen_t cause;
      xlen_t tval;
      logic  valid;
   } exception_t;

   typedef struct packed {
      xlen_t                    result;
      logic [TRANS_ID_BITS-1:0] trans_id;
      exception_t               ex;
   } cfu_wb_entry_t;

   // ProtocolAsserts gates the FU handshake checker
   typedef struct packed {
      int unsigned XLEN;
      bit          ProtocolAsserts;
   } cfg_t;

   localparam cfg_t cva6_cfg_empty = '{XLEN: 32, ProtocolAsserts: 1'b1};

endpackage

// File: rtl/cfu_wb_buffer.sv
// In-order result FIFO between the pattern-fetch FU and writeback.
// Occupancy lives in a count register; full/empty never use pointers.
module cfu_wb_buffer
   import cfu_wb_buffer_pkg::*;
#(
   parameter cfg_t        CVA6Cfg = cva6_cfg_empty,
   parameter int unsigned DEPTH   = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     fu_valid_i,
   input  xlen_t                    fu_result_i,
   input  logic [TRANS_ID_BITS-1:0] fu_trans_id_i,
   input  exception_t               fu_exception_i,
   output logic                     fu_ready_o,
   output logic                     wb_valid_o,
   output xlen_t                    wb_result_o,
   output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
   output exception_t               wb_exception_o,
   input  logic                     wb_grant_i,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   if (CVA6Cfg.XLEN != XLEN) begin : g_bad_xlen
      $error("cfu_wb_buffer: CVA6Cfg.XLEN does not match package XLEN");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("cfu_wb_buffer: DEPTH must be a power of two >= 2");
   end

   cfu_wb_entry_t    r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;

   logic          w_push;
   logic          w_pop;
   cfu_wb_entry_t w_in;
   cfu_wb_entry_t w_head;

   // Handshake outputs decode only the registered count
   assign fu_ready_o = (r_count != FULL);
   assign wb_valid_o = (r_count != '0);

   assign w_push = fu_valid_i && fu_ready_o && !flush_i;
   assign w_pop  = wb_valid_o && wb_grant_i && !flush_i;

   assign w_in.result   = fu_result_i;
   assign w_in.trans_id = fu_trans_id_i;
   assign w_in.ex       = fu_exception_i;

   // Storage is not reset or flushed; validity comes from count
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_in;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (flush_i) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_comb begin
      w_head = '0;
      if (wb_valid_o) begin
         w_head = r_mem[r_rd_ptr];
      end
   end

   assign wb_result_o    = w_head.result;
   assign wb_trans_id_o  = w_head.trans_id;
   assign wb_exception_o = w_head.ex;
   assign count_o        = r_count;

   if (CVA6Cfg.ProtocolAsserts) begin : g_asserts
      a_fu_push_when_full : assert property (
         @(posedge clk_i) disable iff (!rst_ni)
         fu_valid_i |-> fu_ready_o
      );
   end

endmodule

// File: tb/tb_cfu_wb_buffer.sv
// Directed bench for cfu_wb_buffer with DEPTH=2.
// Deliberately violates the FU handshake, so the checker is disabled.
module tb_cfu_wb_buffer;
   import cfu_wb_buffer_pkg::*;

   localparam cfg_t TB_CFG = '{XLEN: 32, ProtocolAsserts: 1'b0};

   logic                     clk;
   logic                     rst_n;
   logic                     flush;
   logic                     fu_valid;
   xlen_t                    fu_result;
   logic [TRANS_ID_BITS-1:0] fu_tid;
   exception_t               fu_ex;
   logic                     fu_ready;
   logic                     wb_valid;
   xlen_t                    wb_result;
   logic [TRANS_ID_BITS-1:0] wb_tid;
   exception_t               wb_ex;
   logic                     wb_grant;
   logic [1:0]               count;

   int pass_cnt = 0;
   int total    = 0;

   cfu_wb_buffer #(.CVA6Cfg(TB_CFG), .DEPTH(2)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .flush_i        (flush),
      .fu_valid_i     (fu_valid),
      .fu_result_i    (fu_result),
      .fu_trans_id_i  (fu_tid),
      .fu_exception_i (fu_ex),
      .fu_ready_o     (fu_ready),
      .wb_valid_o     (wb_valid),
      .wb_result_o    (wb_result),
      .wb_trans_id_o  (wb_tid),
      .wb_exception_o (wb_ex),
      .wb_grant_i     (wb_grant),
      .count_o        (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push(input logic [TRANS_ID_BITS-1:0] id, input xlen_t res);
      fu_valid  = 1'b1;
      fu_tid    = id;
      fu_result = res;
      fu_ex     = '0;
   endtask

   task automatic idle();
      fu_valid  = 1'b0;
      fu_tid    = '0;
      fu_result = '0;
      fu_ex     = '0;
      wb_grant  = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      @(negedge clk);
      total++;
      if ({fu_ready, wb_valid, count} !== 4'b1000) begin
         $display("FAIL reset_ctrl ready/valid/count got %b want 1000",
                  {fu_ready, wb_valid, count});
      end else pass_cnt++;
      total++;
      if (wb_result !== '0 || wb_tid !== '0 || wb_ex !== '0) begin
         $display("FAIL reset_data got res=%h tid=%h ex=%h want zeros",
                  wb_result, wb_tid, wb_ex);
      end else pass_cnt++;
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if ({fu_ready, wb_valid, count} !== 4'b1000) begin
         $display("FAIL idle_ctrl got %b want 1000",
                  {fu_ready, wb_valid, count});
      end else pass_cnt++;
   endtask

   task automatic test_single();
      push(4'd3, 32'hDEAD_BEEF);
      @(negedge clk);
      idle();
      total++;
      if (!(wb_valid === 1'b1 && wb_result === 32'hDEAD_BEEF &&
            wb_tid === 4'd3 && count === 2'd1)) begin
         $display("FAIL single_push got v=%b res=%h tid=%0d cnt=%0d want 1 deadbeef 3 1",
                  wb_valid, wb_result, wb_tid, count);
      end else pass_cnt++;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (!(wb_valid === 1'b1 && wb_result === 32'hDEAD_BEEF &&
               wb_tid === 4'd3 && count === 2'd1)) begin
            $display("FAIL hold_%0d got v=%b res=%h tid=%0d cnt=%0d want 1 deadbeef 3 1",
                     i, wb_valid, wb_result, wb_tid, count);
         end else pass_cnt++;
      end
      wb_grant = 1'b1;
      @(negedge clk);
      wb_grant = 1'b0;
      total++;
      if (!(wb_valid === 1'b0 && count === 2'd0 && wb_result === '0)) begin
         $display("FAIL single_pop got v=%b cnt=%0d res=%h want 0 0 0",
                  wb_valid, count, wb_result);
      end else pass_cnt++;
   endtask

   task automatic test_full();
      push(4'd1, 32'h0000_0101);
      @(negedge clk);
      push(4'd2, 32'h0000_0202);
      @(negedge clk);
      total++;
      if (!(count === 2'd2 && fu_ready === 1'b0 && wb_tid === 4'd1)) begin
         $display("FAIL full got cnt=%0d rdy=%b tid=%0d want 2 0 1",
                  count, fu_ready, wb_tid);
      end else pass_cnt++;
      push(4'd3, 32'h0000_0303);
      @(negedge clk);
      total++;
      if (!(count === 2'd2 && wb_tid === 4'd1 && wb_result === 32'h0000_0101)) begin
         $display("FAIL full_ignore got cnt=%0d tid=%0d res=%h want 2 1 00000101",
                  count, wb_tid, wb_result);
      end else pass_cnt++;
      // Still offering ID 3 while granting: full refuses it even with a pop
      wb_grant = 1'b1;
      @(negedge clk);
      idle();
      wb_grant = 1'b1;
      total++;
      if (!(count === 2'd1 && wb_tid === 4'd2 && wb_result === 32'h0000_0202)) begin
         $display("FAIL order_2 got cnt=%0d tid=%0d res=%h want 1 2 00000202",
                  count, wb_tid, wb_result);
      end else pass_cnt++;
      @(negedge clk);
      idle();
      total++;
      if (!(count === 2'd0 && wb_valid === 1'b0)) begin
         $display("FAIL drain got cnt=%0d v=%b want 0 0", count, wb_valid);
      end else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      push(4'd0, 32'h1000_0000);
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         total++;
         if (!(wb_valid === 1'b1 && wb_tid === 4'(i - 1) &&
               wb_result === 32'h1000_0000 + 32'(i - 1) &&
               count === 2'd1 && fu_ready === 1'b1)) begin
            $display("FAIL b2b_%0d got v=%b tid=%0d res=%h cnt=%0d rdy=%b want tid %0d",
                     i - 1, wb_valid, wb_tid, wb_result, count, fu_ready, i - 1);
         end else pass_cnt++;
         if (i < 10) push(4'(i), 32'h1000_0000 + 32'(i));
         else fu_valid = 1'b0;
         wb_grant = 1'b1;
      end
      @(negedge clk);
      idle();
      total++;
      if (!(wb_valid === 1'b0 && count === 2'd0)) begin
         $display("FAIL b2b_drain got v=%b cnt=%0d want 0 0", wb_valid, count);
      end else pass_cnt++;
   endtask

   task automatic test_flush();
      push(4'd5, 32'h0000_0505);
      @(negedge clk);
      push(4'd6, 32'h0000_0606);
      @(negedge clk);
      total++;
      if (count !== 2'd2) begin
         $display("FAIL flush_pre got cnt=%0d want 2", count);
      end else pass_cnt++;
      flush = 1'b1;
      push(4'd7, 32'h0000_0707);
      @(negedge clk);
      idle();
      total++;
      if (!(count === 2'd0 && wb_valid === 1'b0 && fu_ready === 1'b1 &&
            wb_result === '0)) begin
         $display("FAIL flush got cnt=%0d v=%b rdy=%b res=%h want 0 0 1 0",
                  count, wb_valid, fu_ready, wb_result);
      end else pass_cnt++;
      @(negedge clk);
      total++;
      if (!(wb_valid === 1'b0 && count === 2'd0)) begin
         $display("FAIL flush_no7 got v=%b cnt=%0d tid=%0d want 0 0",
                  wb_valid, count, wb_tid);
      end else pass_cnt++;
   endtask

   task automatic test_exception();
      exception_t ex_exp;
      ex_exp = '{cause: 32'h2, tval: 32'h0000_0ABC, valid: 1'b1};
      push(4'd4, 32'h0000_1234);
      fu_ex = ex_exp;
      @(negedge clk);
      idle();
      total++;
      if (!(wb_valid === 1'b1 && wb_ex === ex_exp && wb_tid === 4'd4 &&
            wb_result === 32'h0000_1234)) begin
         $display("FAIL exception got v=%b ex=%h tid=%0d res=%h want ex=%h tid 4",
                  wb_valid, wb_ex, wb_tid, wb_result, ex_exp);
      end else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (!({fu_ready, wb_valid, count} === 4'b1000 && wb_ex === '0 &&
            wb_result === '0 && wb_tid === '0)) begin
         $display("FAIL async_reset got rdy=%b v=%b cnt=%0d ex=%h res=%h",
                  fu_ready, wb_valid, count, wb_ex, wb_result);
      end else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (!(wb_valid === 1'b0 && count === 2'd0 && fu_ready === 1'b1)) begin
         $display("FAIL post_reset got v=%b cnt=%0d rdy=%b want 0 0 1",
                  wb_valid, count, fu_ready);
      end else pass_cnt++;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      test_reset();
      test_single();
      test_full();
      test_back_to_back();
      test_flush();
      test_exception();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
